// File: rtl/vga_capture.sv
// vga_capture: locks to an external VGA timing source and emits one strobe per active pixel.
// Optional per-frame CRC-16-CCITT of captured pixels when VGA_CAPTURE_CRC_EN is defined.
module vga_capture #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned CLK_PER_PIX = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        Hsync,
    input  logic        Vsync,
    input  logic [7:0]  pixel,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [7:0]  pix_data,
    output logic        frame_start,
    output logic        locked,
    output logic        err_line,
    output logic        err_frame,
    output logic [15:0] frame_count
`ifdef VGA_CAPTURE_CRC_EN
    ,
    output logic [15:0] frame_crc,
    output logic        crc_valid
`endif
);

    localparam logic [13:0] CntMax   = '1;
    localparam int unsigned HStart   = (H_SYNC + H_BP) * CLK_PER_PIX;
    localparam int unsigned LineClks = H_TOTAL * CLK_PER_PIX;
    localparam int unsigned VStart   = V_SYNC + V_BP;

    typedef enum logic [0:0] {StSearch, StSynced} state_e;

    state_e      state_q, state_d;
    logic        hs_q, vs_q, hs_prev_q, vs_prev_q;
    logic [7:0]  pix_q;
    logic [13:0] clk_cnt_q, clk_cnt_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [9:0]  x_q, x_d;
    logic        first_h_q, first_h_d;
    logic        h_edge, v_edge, synced, cnt_sat;
    logic        row_active, sample, line_bad, frame_good;
    logic [9:0]  row;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            hs_prev_q <= 1'b1;
            vs_prev_q <= 1'b1;
            pix_q     <= '0;
        end else begin
            hs_q      <= Hsync;
            vs_q      <= Vsync;
            hs_prev_q <= hs_q;
            vs_prev_q <= vs_q;
            pix_q     <= pixel;
        end
    end

    assign h_edge     = hs_prev_q & ~hs_q;
    assign v_edge     = vs_prev_q & ~vs_q;
    assign synced     = (state_q == StSynced);
    assign locked     = synced;
    assign cnt_sat    = (clk_cnt_q == CntMax);
    assign row        = line_cnt_q - 10'(VStart);
    assign row_active = (32'(line_cnt_q) >= VStart) && (32'(line_cnt_q) < VStart + V_ACTIVE);
    // x_q tracks the next column to sample, avoiding a divide by CLK_PER_PIX.
    assign sample     = synced && row_active && (32'(x_q) < H_ACTIVE) &&
                        (32'(clk_cnt_q) == HStart + 32'(x_q) * CLK_PER_PIX);
    assign line_bad   = (32'(clk_cnt_q) + 32'd1 != LineClks);
    // A coincident Hsync edge closes the last line of the frame.
    assign frame_good = (32'(line_cnt_q) + 32'(h_edge) == V_TOTAL);

    always_comb begin
        clk_cnt_d  = clk_cnt_q;
        line_cnt_d = line_cnt_q;
        x_d        = x_q;
        if (h_edge) begin
            clk_cnt_d = '0;
            x_d       = '0;
        end else begin
            if (!cnt_sat) clk_cnt_d = clk_cnt_q + 14'd1;
            if (sample) x_d = x_q + 10'd1;
        end
        if (v_edge) begin
            line_cnt_d = '0;
        end else if (h_edge) begin
            line_cnt_d = line_cnt_q + 10'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        first_h_d = first_h_q;
        unique case (state_q)
            StSearch: begin
                if (v_edge) begin
                    state_d   = StSynced;
                    first_h_d = 1'b1;
                end
            end
            StSynced: begin
                if (cnt_sat) begin
                    state_d = StSearch;
                end else if (h_edge) begin
                    first_h_d = 1'b0;
                end
            end
            default: state_d = StSearch;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StSearch;
            first_h_q   <= 1'b0;
            clk_cnt_q   <= '0;
            line_cnt_q  <= '0;
            x_q         <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_data    <= '0;
            frame_start <= 1'b0;
            err_line    <= 1'b0;
            err_frame   <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q     <= state_d;
            first_h_q   <= first_h_d;
            clk_cnt_q   <= clk_cnt_d;
            line_cnt_q  <= line_cnt_d;
            x_q         <= x_d;
            pix_valid   <= sample;
            if (sample) begin
                pix_x    <= x_q;
                pix_y    <= row;
                pix_data <= pix_q;
            end
            frame_start <= v_edge;
            err_line    <= synced && h_edge && !first_h_q && line_bad;
            err_frame   <= synced && v_edge && !frame_good;
            if (synced && v_edge && frame_good) frame_count <= frame_count + 16'd1;
        end
    end

`ifdef VGA_CAPTURE_CRC_EN
    logic [15:0] crc_acc_q;

    function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] d);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = (c[15] ^ d[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
        end
        return c;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crc_acc_q <= 16'hFFFF;
            frame_crc <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= synced && v_edge;
            if (synced && v_edge) frame_crc <= crc_acc_q;
            if (v_edge) begin
                crc_acc_q <= 16'hFFFF;
            end else if (pix_valid) begin
                crc_acc_q <= crc_byte(crc_acc_q, pix_data);
            end
        end
    end
`endif

endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter H_SYNC, 96: hsync pulse width, pixels.
REQ-002 Parameter H_BP, 48: horizontal back porch, pixels.
REQ-003 Parameter H_ACTIVE, 640: active pixels per line.
REQ-004 Parameter H_TOTAL, 800: pixels per line, including sync and porches.
REQ-005 Parameter V_SYNC, 2 / V_BP, 33 / V_ACTIVE, 480 / V_TOTAL, 525: vertical equivalents, in lines.
REQ-006 Parameter CLK_PER_PIX, 2: clk cycles per pixel (50 MHz clk, 25 MHz pixel).
REQ-007 clk  input  1  system clock; all logic on rising edge.
REQ-008 resetn  input  1  asynchronous, active-low reset.
REQ-009 Hsync  input  1  horizontal sync, active low, clk-synchronous.
REQ-010 Vsync  input  1  vertical sync, active low, clk-synchronous.
REQ-011 pixel  input  8  RGB332 (R[7:5] G[4:2] B[1:0]).
REQ-012 pix_valid  output  1  one-cycle strobe: pix_x/pix_y/pix_data hold an active pixel.
REQ-013 pix_x  output  10  active column, 0..H_ACTIVE-1.
REQ-014 pix_y  output  10  active row, 0..V_ACTIVE-1.
REQ-015 pix_data  output  8  captured pixel.
REQ-016 frame_start  output  1  one-cycle pulse on every registered Vsync falling edge.
REQ-017 locked  output  1  high while the block is in state SYNCED.
REQ-018 err_line  output  1  one-cycle pulse on a bad line length.
REQ-019 err_frame  output  1  one-cycle pulse on a bad frame length.
REQ-020 frame_count  output  16  count of completed good frames; wraps 0xFFFF->0.

Function
REQ-021 Hsync, Vsync and pixel SHALL be registered once; all edge detection and sampling SHALL use the registered copies.
REQ-022 A horizontal edge SHALL be a registered Hsync 1->0 transition; a vertical edge SHALL be the same on registered Vsync.
REQ-023 Counter clk_cnt SHALL clear to 0 on a horizontal edge and increment otherwise, saturating at 2^14-1.
REQ-024 line_cnt SHALL clear to 0 on a vertical edge and increment on every horizontal edge.
- Simultaneous horizontal and vertical edges: the vertical clear wins.
REQ-025 FSM states:
- SEARCH: reset state; goes to SYNCED on the first vertical edge.
- SYNCED: goes to SEARCH when clk_cnt saturates (input lost); otherwise stays.
REQ-026 In SYNCED, a sample point SHALL occur when clk_cnt = (H_SYNC+H_BP+x)*CLK_PER_PIX, for x in 0..H_ACTIVE-1, and line_cnt-(V_SYNC+V_BP) in 0..V_ACTIVE-1.
REQ-027 On the cycle after a sample point, the block SHALL:
- assert pix_valid;
- drive pix_x = x, pix_y = line_cnt-(V_SYNC+V_BP);
- drive pix_data = registered pixel at the sample point.
Latency: input to pix_data is 2 clk.
REQ-028 pix_valid SHALL never assert in SEARCH, in porches, or in sync intervals.
- pix_x, pix_y and pix_data SHALL hold their last values when pix_valid is low.
REQ-029 In SYNCED, a horizontal edge with clk_cnt+1 != H_TOTAL*CLK_PER_PIX SHALL pulse err_line the next cycle.
- The first horizontal edge after entering SYNCED is exempt.
REQ-030 In SYNCED, a vertical edge with line_cnt != V_TOTAL SHALL:
- pulse err_frame;
- leave frame_count unchanged;
- keep the FSM in SYNCED, realigned to the new edge.
If line_cnt = V_TOTAL, frame_count SHALL increment instead.
REQ-031 The vertical edge that causes SEARCH->SYNCED SHALL pulse frame_start only.
- It SHALL NOT pulse err_frame and SHALL NOT increment frame_count.
REQ-032 frame_start, err_line and err_frame SHALL be registered outputs, asserted the cycle after the detecting edge.

Reset
REQ-033 While resetn is low, the block SHALL force:
- all outputs to 0;
- all counters to 0;
- FSM to SEARCH;
- input registers to Hsync=1, Vsync=1, pixel=0.
REQ-034 Deassertion mid-frame SHALL require a fresh vertical edge before any pix_valid.
- No error pulse SHALL result from the partial frame.

Configuration
REQ-035 Macro VGA_CAPTURE_CRC_EN.
- When defined: add outputs frame_crc [15:0] and crc_valid [1].
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first) over pix_data of every pix_valid in the frame.
  - On each vertical edge in SYNCED: frame_crc latches the CRC and crc_valid pulses with frame_start, good frame or bad.
  - The accumulator then reinitialises to 0xFFFF.
- When undefined: these ports and the CRC logic SHALL be absent; all other behaviour is identical.

Verification
REQ-036 Reset release, then a standard 800x525 timing source with pixel = x[7:0] -> locked=1 after the first Vsync fall; 307200 pix_valid per frame; first at pix_x=0, pix_y=0, pix_data=0x00; last at pix_x=639, pix_y=479, pix_data=0x7F.
REQ-037 Two good frames -> frame_count = 1 after the second Vsync fall; err_line = 0 and err_frame = 0 throughout.
REQ-038 Shorten one line to 798 pixels -> exactly one err_line pulse, one cycle after that line's closing Hsync fall; capture continues.
REQ-039 Frame of 524 lines -> err_frame pulses; frame_count unchanged; next 525-line frame increments frame_count.
REQ-040 Hold Hsync high for 16384 clk -> locked falls to 0; no pix_valid until the next Vsync fall.
REQ-041 With VGA_CAPTURE_CRC_EN and a constant 0x00 frame -> crc_valid pulse with frame_crc equal to the golden-model CRC over 307200 zero bytes; drop resetn mid-frame -> all outputs 0 within the same cycle.
